ones_frame_deserializer: RTL and testbench



---
 rtl/ones_pkg.sv | 33 +++
 rtl/ones_frame_deserializer.sv | 107 ++++++++++
 tb/tb_ones_frame_deserializer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ones_pkg.sv
// Shared definitions for the ones-counter chain: the deserializer state
// encoding, the standard frame widths with their count widths, and a
// reference popcount helper.
package ones_pkg;

    typedef enum logic {
        S_FILL = 1'b0,   // collecting serial bits into the frame
        S_HOLD = 1'b1    // frame complete, waiting for the consumer
    } fill_state_t;

    // Standard frame widths matching OnesCounter7/15/31/63
    localparam int W7  = 7;
    localparam int W15 = 15;
    localparam int W31 = 31;
    localparam int W63 = 63;

    // Count widths for the standard frames ($clog2(W+1))
    localparam int CNT7  = 3;
    localparam int CNT15 = 4;
    localparam int CNT31 = 5;
    localparam int CNT63 = 6;

    // Number of set bits in a frame of up to 63 bits
    function automatic int unsigned count_ones(input logic [62:0] w);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 63; i++) begin
            n += int'(w[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/ones_frame_deserializer.sv
// Serial-to-parallel front end: shifts bits MSB-first into a WIDTH-bit frame
// and hands the completed frame to the ones counter under valid/ready.
//
// Handshake: a serial bit is taken on any rising edge where
// bit_valid && bit_ready; a frame is taken on any rising edge where
// word_valid && word_ready. word_valid and word_out are stable while waiting,
// and bit_valid never influences bit_ready. In S_HOLD bit_ready follows
// word_ready so a new frame can start in the same cycle the old one leaves.
module ones_frame_deserializer
    import ones_pkg::*;
#(
    parameter int WIDTH = 63,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic [CNT_W-1:0] fill_level
);

    fill_state_t      state;
    fill_state_t      state_nxt;
    logic [WIDTH-1:0] word_q;
    logic [WIDTH-1:0] word_nxt;
    logic [CNT_W-1:0] fill_q;
    logic [CNT_W-1:0] fill_nxt;
    logic             accept;
    logic             handoff;

    // Handshake outputs decoded from the state register (word_ready only matters in S_HOLD)
    always_comb begin
        bit_ready  = 1'b1;
        word_valid = 1'b0;
        if (state == S_HOLD) begin
            bit_ready  = word_ready;
            word_valid = 1'b1;
        end
    end

    assign accept     = bit_valid && bit_ready;
    assign handoff    = word_valid && word_ready;
    assign word_out   = word_q;
    assign fill_level = fill_q;

    // Next-state logic: shift on accept, freeze while held, restart on handoff, abort on clear
    always_comb begin
        state_nxt = state;
        word_nxt  = word_q;
        fill_nxt  = fill_q;
        if (clear) begin
            // Abort: any bit or handoff in this cycle is dropped
            state_nxt = S_FILL;
            word_nxt  = '0;
            fill_nxt  = '0;
        end else begin
            case (state)
                S_FILL: begin
                    if (accept) begin
                        word_nxt = {word_q[WIDTH-2:0], bit_in};
                        fill_nxt = fill_q + CNT_W'(1);
                        if (fill_q == CNT_W'(WIDTH - 1)) begin
                            state_nxt = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (handoff) begin
                        state_nxt = S_FILL;
                        if (accept) begin
                            // Bit arriving with the handoff opens the next frame
                            word_nxt = {{(WIDTH-1){1'b0}}, bit_in};
                            fill_nxt = CNT_W'(1);
                        end else begin
                            word_nxt = '0;
                            fill_nxt = '0;
                        end
                    end
                end
                default: begin
                    state_nxt = S_FILL;
                    word_nxt  = '0;
                    fill_nxt  = '0;
                end
            endcase
        end
    end

    // State, frame and fill registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_FILL;
            word_q <= '0;
            fill_q <= '0;
        end else begin
            state  <= state_nxt;
            word_q <= word_nxt;
            fill_q <= fill_nxt;
        end
    end

endmodule

// File: tb/tb_ones_frame_deserializer.sv
// Bench for ones_frame_deserializer at widths 7, 15 and 63.
module tb_ones_frame_deserializer;
    import ones_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic             clr7, bi7, bv7, br7, wv7, wr7;
    logic [W7-1:0]    wo7;
    logic [CNT7-1:0]  fl7;

    logic             clr15, bi15, bv15, br15, wv15, wr15;
    logic [W15-1:0]   wo15;
    logic [CNT15-1:0] fl15;

    logic             clr63, bi63, bv63, br63, wv63, wr63;
    logic [W63-1:0]   wo63;
    logic [CNT63-1:0] fl63;

    ones_frame_deserializer #(.WIDTH(W7), .CNT_W(CNT7)) u_w7 (
        .clk(clk), .rst_n(rst_n), .clear(clr7), .bit_in(bi7), .bit_valid(bv7),
        .bit_ready(br7), .word_out(wo7), .word_valid(wv7), .word_ready(wr7),
        .fill_level(fl7)
    );

    ones_frame_deserializer #(.WIDTH(W15), .CNT_W(CNT15)) u_w15 (
        .clk(clk), .rst_n(rst_n), .clear(clr15), .bit_in(bi15), .bit_valid(bv15),
        .bit_ready(br15), .word_out(wo15), .word_valid(wv15), .word_ready(wr15),
        .fill_level(fl15)
    );

    ones_frame_deserializer #(.WIDTH(W63), .CNT_W(CNT63)) u_w63 (
        .clk(clk), .rst_n(rst_n), .clear(clr63), .bit_in(bi63), .bit_valid(bv63),
        .bit_ready(br63), .word_out(wo63), .word_valid(wv63), .word_ready(wr63),
        .fill_level(fl63)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- WIDTH=7 vector table ----------------
    typedef struct {
        logic          bv;
        logic          bi;
        logic          wr;
        logic          clr;
        logic          e_wv;
        logic          e_br;
        logic [2:0]    e_fill;
        logic [W7-1:0] e_word;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic bv, input logic bi, input logic wr, input logic clr,
                       input logic e_wv, input logic e_br, input logic [2:0] e_fill,
                       input logic [W7-1:0] e_word);
        vec_t v;
        v.bv = bv; v.bi = bi; v.wr = wr; v.clr = clr;
        v.e_wv = e_wv; v.e_br = e_br; v.e_fill = e_fill; v.e_word = e_word;
        vecs.push_back(v);
    endtask

    // Expected values describe the cycle in which the inputs are applied (before the edge)
    task automatic build_table();
        // Frame 0010101, word_ready high: valid for exactly one cycle
        add(1,0,1,0, 0,1,3'd0,7'b0000000);
        add(1,0,1,0, 0,1,3'd1,7'b0000000);
        add(1,1,1,0, 0,1,3'd2,7'b0000000);
        add(1,0,1,0, 0,1,3'd3,7'b0000001);
        add(1,1,1,0, 0,1,3'd4,7'b0000010);
        add(1,0,1,0, 0,1,3'd5,7'b0000101);
        add(1,1,1,0, 0,1,3'd6,7'b0001010);
        add(0,0,1,0, 1,1,3'd7,7'b0010101);
        add(0,0,1,0, 0,1,3'd0,7'b0000000);
        // Frame 1110101 with the consumer stalled for 5 cycles
        add(1,1,0,0, 0,1,3'd0,7'b0000000);
        add(1,1,0,0, 0,1,3'd1,7'b0000001);
        add(1,1,0,0, 0,1,3'd2,7'b0000011);
        add(1,0,0,0, 0,1,3'd3,7'b0000111);
        add(1,1,0,0, 0,1,3'd4,7'b0001110);
        add(1,0,0,0, 0,1,3'd5,7'b0011101);
        add(1,1,0,0, 0,1,3'd6,7'b0111010);
        for (int i = 0; i < 5; i++) add(1,0,0,0, 1,0,3'd7,7'b1110101);
        // Release: handoff with a simultaneous bit opens the next frame
        add(1,1,1,0, 1,1,3'd7,7'b1110101);
        add(1,0,1,0, 0,1,3'd1,7'b0000001);
        // Gaps leave the partial frame untouched
        add(0,0,1,0, 0,1,3'd2,7'b0000010);
        add(0,1,0,0, 0,1,3'd2,7'b0000010);
        add(1,1,0,0, 0,1,3'd2,7'b0000010);
        add(1,1,0,0, 0,1,3'd3,7'b0000101);
        // Clear after 4 bits, bit in the clear cycle is dropped
        add(1,1,0,1, 0,1,3'd4,7'b0001011);
        add(0,0,0,0, 0,1,3'd0,7'b0000000);
        // Frame 0001001
        add(1,0,0,0, 0,1,3'd0,7'b0000000);
        add(1,0,0,0, 0,1,3'd1,7'b0000000);
        add(1,0,0,0, 0,1,3'd2,7'b0000000);
        add(1,1,0,0, 0,1,3'd3,7'b0000000);
        add(1,0,0,0, 0,1,3'd4,7'b0000001);
        add(1,0,0,0, 0,1,3'd5,7'b0000010);
        add(1,1,0,0, 0,1,3'd6,7'b0000100);
        add(0,0,0,0, 1,0,3'd7,7'b0001001);
        // Clear wins over a handoff-with-accept in S_HOLD
        add(1,1,1,1, 1,1,3'd7,7'b0001001);
        add(0,0,0,0, 0,1,3'd0,7'b0000000);
    endtask

    // ---------------- WIDTH=63 model state ----------------
    logic [W63-1:0] exp_q[$];
    logic [W63-1:0] m_word;
    logic [W63-1:0] exp_w;
    int             m_cnt;
    int             frames63;
    logic           m_hold;
    logic           e_br;

    // ---------------- WIDTH=15 frames ----------------
    logic [W15-1:0] frame1;
    logic [W15-1:0] frame2;
    int             exp_fill15;

    initial begin
        rst_n = 1'b0;
        clr7 = 0;  bi7 = 0;  bv7 = 0;  wr7 = 0;
        clr15 = 0; bi15 = 0; bv15 = 0; wr15 = 0;
        clr63 = 0; bi63 = 0; bv63 = 0; wr63 = 0;
        build_table();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;

        // ---- reset state ----
        check("rst_w7_valid", wv7, 0);
        check("rst_w7_ready", br7, 1);
        check("rst_w7_fill",  fl7, 0);
        check("rst_w7_word",  wo7, 0);
        check("rst_w63_valid", wv63, 0);
        check("rst_w63_fill",  fl63, 0);

        // ---- WIDTH=7 table ----
        foreach (vecs[i]) begin
            bv7 = vecs[i].bv; bi7 = vecs[i].bi; wr7 = vecs[i].wr; clr7 = vecs[i].clr;
            #1;
            check($sformatf("w7_v%0d_valid", i), wv7, vecs[i].e_wv);
            check($sformatf("w7_v%0d_ready", i), br7, vecs[i].e_br);
            check($sformatf("w7_v%0d_fill",  i), fl7, vecs[i].e_fill);
            check($sformatf("w7_v%0d_word",  i), wo7, vecs[i].e_word);
            if (vecs[i].e_wv) begin
                check($sformatf("w7_v%0d_ones", i), count_ones(63'(wo7)),
                      count_ones(63'(vecs[i].e_word)));
            end
            tick();
        end
        bv7 = 0; wr7 = 0; clr7 = 0;

        // ---- async reset while holding a frame ----
        bv7 = 1; bi7 = 1; wr7 = 0;
        repeat (7) tick();
        bv7 = 0;
        #1;
        check("ar_hold_valid", wv7, 1);
        check("ar_hold_fill",  fl7, 7);
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid", wv7, 0);
        check("ar_word",  wo7, 0);
        check("ar_fill",  fl7, 0);
        #1 rst_n = 1'b1;
        #1;
        check("ar_ready_after", br7, 1);
        check("ar_valid_after", wv7, 0);
        tick();

        // ---- WIDTH=15 back-to-back frames ----
        frame1 = 15'b101100111000110;
        frame2 = 15'b111010101010000;
        for (int k = 0; k < 32; k++) begin
            bv15 = 1; wr15 = 1;
            if (k < 15)      bi15 = frame1[14 - k];
            else if (k < 30) bi15 = frame2[29 - k];
            else             bi15 = 1'b0;
            #1;
            exp_fill15 = (k == 0) ? 0 : ((k - 1) % 15) + 1;
            check($sformatf("w15_k%0d_valid", k), wv15, (k == 15 || k == 30));
            check($sformatf("w15_k%0d_fill", k), fl15, exp_fill15);
            check($sformatf("w15_k%0d_ready", k), br15, 1);
            if (k == 15) check("w15_frame1", wo15, frame1);
            if (k == 30) begin
                check("w15_frame2", wo15, frame2);
                check("w15_frame2_ones", count_ones(63'(wo15)), 7);
            end
            tick();
        end
        bv15 = 0; wr15 = 0;

        // ---- WIDTH=63 random gaps and stalls against a bit-level model ----
        m_cnt = 0; m_word = '0; frames63 = 0;
        for (int c = 0; c < 3000; c++) begin
            bv63 = ($urandom_range(0, 9) < 7);
            bi63 = 1'($urandom_range(0, 1));
            wr63 = ($urandom_range(0, 1) == 1);
            #1;
            m_hold = (m_cnt == 63);
            e_br   = m_hold ? wr63 : 1'b1;
            check("w63_ready", br63, e_br);
            check("w63_valid", wv63, m_hold);
            check("w63_fill",  fl63, m_cnt);
            if (m_hold && wr63) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL w63_queue: handoff with no expected frame at %0t", $time);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("w63_word", wo63, exp_w);
                    check("w63_ones", count_ones(wo63), count_ones(exp_w));
                    frames63++;
                end
                m_cnt  = 0;
                m_word = '0;
            end
            if (bv63 && e_br) begin
                m_word = {m_word[W63-2:0], bi63};
                m_cnt++;
                if (m_cnt == 63) exp_q.push_back(m_word);
            end
            tick();
        end
        bv63 = 0; wr63 = 0;
        check("w63_frames_seen", (frames63 >= 10), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
